// File: rtl/midi_pkg.sv
// Shared MIDI transmit definitions: status nibbles, FSM encodings and the
// status-byte helper used by the encoder.
package midi_pkg;

    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;

    typedef enum logic [1:0] {
        MSG_IDLE,
        MSG_STAT,
        MSG_NOTE,
        MSG_VEL
    } msg_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_t;

    // Note-off can be sent as a note-on (velocity is zeroed by the caller).
    function automatic logic [7:0] status_byte(input logic on, input logic [3:0] ch,
                                               input logic noteoff_as_on);
        return {(on || noteoff_as_on) ? MIDI_NOTE_ON : MIDI_NOTE_OFF, ch};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. Byte and bit period are latched on start;
// a start on the last stop-bit cycle chains the next byte with no idle gap.
module uart_tx_byte
    import midi_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_res,
    input  logic        i_start,
    input  logic [7:0]  i_data,
    input  logic [15:0] i_baud,
    output logic        o_tx,
    output logic        o_done,
    output ser_state_t  o_state
);

    ser_state_t  state_next;
    logic [15:0] div_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        bit_end;
    logic        load;

    assign bit_end = (div_q == baud_q);
    assign load    = i_start && ((o_state == SER_IDLE) || ((o_state == SER_STOP) && bit_end));

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            o_state <= SER_IDLE;
        end else begin
            o_state <= state_next;
        end
    end

    always_comb begin
        state_next = o_state;
        case (o_state)
            SER_IDLE:  if (i_start) state_next = SER_START;
            SER_START: if (bit_end) state_next = SER_DATA;
            SER_DATA:  if (bit_end && (bit_q == 3'd7)) state_next = SER_STOP;
            SER_STOP:  if (bit_end) state_next = i_start ? SER_START : SER_IDLE;
            default:   state_next = SER_IDLE;
        endcase
    end

    always_comb begin
        o_tx   = 1'b1;
        o_done = 1'b0;
        case (o_state)
            SER_START: o_tx = 1'b0;
            SER_DATA:  o_tx = shift_q[0];
            SER_STOP:  o_done = bit_end;
            default:   ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            div_q   <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else if (load) begin
            shift_q <= i_data;
            baud_q  <= i_baud;
            div_q   <= '0;
            bit_q   <= '0;
        end else if (o_state != SER_IDLE) begin
            if (bit_end) begin
                div_q <= '0;
                if (o_state == SER_DATA) begin
                    shift_q <= shift_q >> 1;
                    bit_q   <= bit_q + 3'd1;
                end
            end else begin
                div_q <= div_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/midi_tx_encoder.sv
// MIDI note-event encoder: builds status/note/velocity bytes with optional
// running status and streams them through the byte serializer.
module midi_tx_encoder
    import midi_pkg::*;
#(
    parameter bit P_RUNNING_STATUS = 1'b1,
    parameter bit P_NOTEOFF_AS_ON  = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_res,
    input  logic [15:0] i_baud,
    input  logic        i_ev_valid,
    output logic        o_ev_ready,
    input  logic        i_ev_on,
    input  logic [3:0]  i_ev_ch,
    input  logic [6:0]  i_ev_note,
    input  logic [6:0]  i_ev_vel,
    input  logic        i_rs_clear,
    output logic        o_tx,
    output logic        o_busy,
    output msg_state_t  o_dbg_msg_state,
    output ser_state_t  o_dbg_ser_state
);

    // Handshake: an event transfers on any cycle with i_ev_valid && o_ev_ready;
    // ready is high only in MSG_IDLE, so fields are free to change otherwise.
    msg_state_t state;
    msg_state_t state_next;
    logic       accept;
    logic       skip_stat;
    logic       ser_start;
    logic       ser_done;
    logic [7:0] ser_data;
    logic [7:0] new_status;
    logic [7:0] status_q;
    logic [7:0] last_status;
    logic [6:0] new_vel;
    logic [6:0] note_q;
    logic [6:0] vel_q;
    logic       rs_valid;
    logic       rs_clear_pend;

    assign accept     = i_ev_valid && (state == MSG_IDLE);
    assign new_status = status_byte(i_ev_on, i_ev_ch, P_NOTEOFF_AS_ON);
    assign new_vel    = (!i_ev_on && P_NOTEOFF_AS_ON) ? 7'd0 : i_ev_vel;
    assign skip_stat  = P_RUNNING_STATUS && rs_valid && (new_status == last_status);

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state <= MSG_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MSG_IDLE: if (accept) state_next = skip_stat ? MSG_NOTE : MSG_STAT;
            MSG_STAT: if (ser_done) state_next = MSG_NOTE;
            MSG_NOTE: if (ser_done) state_next = MSG_VEL;
            MSG_VEL:  if (ser_done) state_next = MSG_IDLE;
            default:  state_next = MSG_IDLE;
        endcase
    end

    // The first byte is taken straight from the inputs so it starts on the
    // cycle after accept; later bytes chain on the serializer's done pulse.
    always_comb begin
        o_ev_ready = 1'b0;
        ser_start  = 1'b0;
        ser_data   = 8'h00;
        case (state)
            MSG_IDLE: begin
                o_ev_ready = 1'b1;
                ser_start  = accept;
                ser_data   = skip_stat ? {1'b0, i_ev_note} : new_status;
            end
            MSG_STAT: begin
                ser_start = ser_done;
                ser_data  = {1'b0, note_q};
            end
            MSG_NOTE: begin
                ser_start = ser_done;
                ser_data  = {1'b0, vel_q};
            end
            default: ;
        endcase
        o_busy = !o_ev_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            status_q <= '0;
            note_q   <= '0;
            vel_q    <= '0;
        end else if (accept) begin
            status_q <= new_status;
            note_q   <= i_ev_note;
            vel_q    <= new_vel;
        end
    end

    // A clear seen during a message is held until the message ends so the
    // status byte completing in between cannot revalidate the flag.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            rs_valid      <= 1'b0;
            rs_clear_pend <= 1'b0;
            last_status   <= '0;
        end else begin
            if ((state == MSG_STAT) && ser_done) begin
                rs_valid    <= 1'b1;
                last_status <= status_q;
            end
            if (i_rs_clear || rs_clear_pend) begin
                rs_valid <= 1'b0;
            end
            rs_clear_pend <= (i_rs_clear || rs_clear_pend) && (state_next != MSG_IDLE);
        end
    end

    uart_tx_byte u_ser (
        .i_clk   (i_clk),
        .i_res   (i_res),
        .i_start (ser_start),
        .i_data  (ser_data),
        .i_baud  (i_baud),
        .o_tx    (o_tx),
        .o_done  (ser_done),
        .o_state (o_dbg_ser_state)
    );

    assign o_dbg_msg_state = state;

endmodule

// File: tb/tb_midi_tx_encoder.sv
// Bench for midi_tx_encoder: two instances (plain and note-off-as-on), a UART
// line decoder per instance, and a message-level model feeding byte queues.
module tb_midi_tx_encoder;
    import midi_pkg::*;

    logic        clk = 1'b0;
    logic        res;
    logic [15:0] baud;
    logic        ev_on;
    logic [3:0]  ev_ch;
    logic [6:0]  ev_note;
    logic [6:0]  ev_vel;
    logic        rs_clear;
    logic        ev_valid [2];
    logic        ev_ready [2];
    logic        tx [2];
    logic        busy [2];
    msg_state_t  msg_st [2];
    ser_state_t  ser_st [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    bit         m_valid [2];
    logic [7:0] m_last [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    midi_tx_encoder #(.P_RUNNING_STATUS(1'b1), .P_NOTEOFF_AS_ON(1'b0)) dut (
        .i_clk(clk), .i_res(res), .i_baud(baud), .i_ev_valid(ev_valid[0]),
        .o_ev_ready(ev_ready[0]), .i_ev_on(ev_on), .i_ev_ch(ev_ch), .i_ev_note(ev_note),
        .i_ev_vel(ev_vel), .i_rs_clear(rs_clear), .o_tx(tx[0]), .o_busy(busy[0]),
        .o_dbg_msg_state(msg_st[0]), .o_dbg_ser_state(ser_st[0])
    );

    midi_tx_encoder #(.P_RUNNING_STATUS(1'b1), .P_NOTEOFF_AS_ON(1'b1)) dut_nao (
        .i_clk(clk), .i_res(res), .i_baud(baud), .i_ev_valid(ev_valid[1]),
        .o_ev_ready(ev_ready[1]), .i_ev_on(ev_on), .i_ev_ch(ev_ch), .i_ev_note(ev_note),
        .i_ev_vel(ev_vel), .i_rs_clear(rs_clear), .o_tx(tx[1]), .o_busy(busy[1]),
        .o_dbg_msg_state(msg_st[1]), .o_dbg_ser_state(ser_st[1])
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic void exp_push(input int d, input logic [7:0] b);
        if (d == 0) exp_q0.push_back(b);
        else exp_q1.push_back(b);
    endfunction

    // Message model: status resent unless it matches the last one sent.
    task automatic model_event(input int d, input logic on, input logic [3:0] ch,
                               input logic [6:0] note, input logic [6:0] vel, output int nb);
        logic [7:0] st;
        logic [6:0] v;
        v = vel;
        if (on) st = {4'h9, ch};
        else if (d == 1) begin st = {4'h9, ch}; v = 7'd0; end
        else st = {4'h8, ch};
        nb = 2;
        if (!(m_valid[d] && (m_last[d] == st))) begin
            exp_push(d, st);
            nb = 3;
            m_valid[d] = 1'b1;
            m_last[d] = st;
        end
        exp_push(d, {1'b0, note});
        exp_push(d, {1'b0, v});
    endtask

    function automatic void model_clear();
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
    endfunction

    function automatic void model_reset();
        model_clear();
        exp_q0.delete();
        exp_q1.delete();
    endfunction

    // Line decoder: bit period comes from i_baud on the cycle before the start bit.
    task automatic uart_mon(input int d);
        int pb, cb, t;
        logic [7:0] b;
        logic [8:0] want;
        logic lvl;
        bit bad, abort;
        pb = 0;
        cb = 0;
        forever begin
            @(negedge clk);
            pb = cb;
            cb = int'(baud);
            if (res !== 1'b0 || tx[d] !== 1'b0) continue;
            t = pb + 1;
            bad = 1'b0;
            abort = 1'b0;
            b = 8'h00;
            for (int bi = 0; bi < 10; bi++) begin
                for (int c = 0; c < t; c++) begin
                    if (bi != 0 || c != 0) begin
                        @(negedge clk);
                        pb = cb;
                        cb = int'(baud);
                    end
                    if (res !== 1'b0) abort = 1'b1;
                    if (abort) break;
                    lvl = tx[d];
                    if (bi == 0) begin
                        if (lvl !== 1'b0) bad = 1'b1;
                    end else if (bi == 9) begin
                        if (lvl !== 1'b1) bad = 1'b1;
                    end else if (c == 0) begin
                        b[bi-1] = lvl;
                    end else if (lvl !== b[bi-1]) begin
                        bad = 1'b1;
                    end
                end
                if (abort) break;
            end
            if (!abort) begin
                check($sformatf("frame%0d", d), {31'b0, bad}, 32'd0);
                want = 9'h100;
                if (d == 0 && exp_q0.size() > 0) want = {1'b0, exp_q0.pop_front()};
                if (d == 1 && exp_q1.size() > 0) want = {1'b0, exp_q1.pop_front()};
                check($sformatf("byte%0d", d), {24'b0, b}, {23'b0, want});
            end
        end
    endtask

    initial uart_mon(0);
    initial uart_mon(1);

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (ev_ready[d] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("ready_timeout", {31'b0, ev_ready[d]}, 32'd1);
    endtask

    task automatic post_accept(input int d, input logic on, input logic [3:0] ch,
                               input logic [6:0] note, input logic [6:0] vel,
                               input bit keep, output int nb);
        model_event(d, on, ch, note, vel, nb);
        #1;
        if (!keep) ev_valid[d] = 1'b0;
        @(negedge clk);
        check("start_latency", {31'b0, tx[d]}, 32'd0);
        check("busy_high", {31'b0, busy[d]}, 32'd1);
        check("ready_low", {31'b0, ev_ready[d]}, 32'd0);
        acc_cyc = cyc;
    endtask

    task automatic send_begin(input int d, input logic on, input logic [3:0] ch,
                              input logic [6:0] note, input logic [6:0] vel, output int nb);
        wait_ready(d);
        @(posedge clk);
        #1;
        ev_on = on;
        ev_ch = ch;
        ev_note = note;
        ev_vel = vel;
        ev_valid[d] = 1'b1;
        @(posedge clk);
        post_accept(d, on, ch, note, vel, 1'b0, nb);
    endtask

    task automatic wait_done(input int d, input int exp_len);
        int n;
        n = 0;
        while (ev_ready[d] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("msg_len", cyc - acc_cyc, exp_len);
        check("busy_low", {31'b0, busy[d]}, 32'd0);
    endtask

    task automatic send(input int d, input logic on, input logic [3:0] ch,
                        input logic [6:0] note, input logic [6:0] vel);
        int nb;
        send_begin(d, on, ch, note, vel, nb);
        wait_done(d, 10 * nb * (int'(baud) + 1));
    endtask

    initial begin
        int nb, k, sel, d;
        res = 1'b1;
        baud = 16'd3;
        ev_on = 1'b0;
        ev_ch = 4'd0;
        ev_note = 7'd0;
        ev_vel = 7'd0;
        rs_clear = 1'b0;
        ev_valid[0] = 1'b0;
        ev_valid[1] = 1'b0;
        model_reset();

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_tx", {31'b0, tx[0]}, 32'd1);
            check("rst_ready", {31'b0, ev_ready[0]}, 32'd1);
            check("rst_busy", {31'b0, busy[0]}, 32'd0);
        end
        check("rst_msg_state", {30'b0, msg_st[0]}, {30'b0, MSG_IDLE});
        check("rst_ser_state", {30'b0, ser_st[1]}, {30'b0, SER_IDLE});
        @(posedge clk);
        #1 res = 1'b0;

        // Directed messages and running status.
        send(0, 1'b1, 4'd0, 7'd60, 7'd100);
        send(0, 1'b1, 4'd0, 7'd64, 7'd0);
        send(0, 1'b0, 4'd1, 7'd64, 7'd10);
        send(1, 1'b0, 4'd2, 7'd50, 7'd77);
        send(1, 1'b1, 4'd2, 7'd51, 7'd5);

        // Clear mid-message with valid held and fields churning while busy.
        wait_ready(0);
        @(posedge clk);
        #1;
        ev_on = 1'b0; ev_ch = 4'd1; ev_note = 7'd70; ev_vel = 7'd1;
        ev_valid[0] = 1'b1;
        @(posedge clk);
        post_accept(0, 1'b0, 4'd1, 7'd70, 7'd1, 1'b1, nb);
        k = 0;
        while (ev_ready[0] !== 1'b1 && k < 1000) begin
            rs_clear = (k == 10);
            if (k == 10) model_clear();
            ev_on = 1'($urandom_range(0, 1));
            ev_ch = 4'($urandom_range(0, 15));
            ev_note = 7'($urandom_range(0, 127));
            ev_vel = 7'($urandom_range(0, 127));
            @(negedge clk);
            k++;
        end
        rs_clear = 1'b0;
        check("msg_len_bp", cyc - acc_cyc, 80);
        ev_on = 1'b0; ev_ch = 4'd1; ev_note = 7'd20; ev_vel = 7'd30;
        @(posedge clk);
        post_accept(0, 1'b0, 4'd1, 7'd20, 7'd30, 1'b0, nb);
        wait_done(0, 120);

        // Reset during the note byte abandons it and forgets running status.
        send_begin(0, 1'b1, 4'd5, 7'd40, 7'd41, nb);
        repeat (50) @(negedge clk);
        @(posedge clk);
        #1 res = 1'b1;
        model_reset();
        @(posedge clk);
        #1 res = 1'b0;
        @(negedge clk);
        check("midrst_tx", {31'b0, tx[0]}, 32'd1);
        check("midrst_ready", {31'b0, ev_ready[0]}, 32'd1);
        check("midrst_busy", {31'b0, busy[0]}, 32'd0);
        send(0, 1'b1, 4'd5, 7'd40, 7'd41);

        // Baud change inside the status byte applies from the note byte on.
        send_begin(0, 1'b1, 4'd6, 7'd11, 7'd22, nb);
        repeat (15) @(posedge clk);
        #1 baud = 16'd1;
        wait_done(0, 40 + 20 + 20);
        @(posedge clk);
        #1 baud = 16'd3;

        // Randomized traffic on both instances.
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            sel = $urandom_range(0, 2);
            baud = (sel == 0) ? 16'd0 : (sel == 1) ? 16'd1 : 16'd3;
            if ($urandom_range(0, 5) == 0) begin
                rs_clear = 1'b1;
                @(posedge clk);
                #1 rs_clear = 1'b0;
                model_clear();
            end
            d = $urandom_range(0, 1);
            send(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 2)),
                 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
        end

        repeat (5) @(negedge clk);
        check("leftover0", exp_q0.size(), 32'd0);
        check("leftover1", exp_q1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
